// File: rtl/pid_pkg.sv
// Shared widths, defaults and saturation helper for the PID datapath.
package pid_pkg;

    localparam int unsigned ERR_W   = 11;
    localparam int unsigned DIFF_W  = 8;
    localparam int unsigned COEFF_W = 7;
    localparam int unsigned DEPTH   = 2;

    localparam logic [COEFF_W-1:0] D_COEFF_DFLT = 7'h38;

    // Clamp a sign-extended in_w-bit value to the signed out_w-bit range.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int unsigned in_w,
                                                      input int unsigned out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (in_w <= out_w) return x;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/err_hist.sv
// Ring buffer of the last DEPTH accepted error samples; exposes the oldest entry.
module err_hist import pid_pkg::*; #(
    parameter int unsigned ERR_W = pid_pkg::ERR_W,
    parameter int unsigned DEPTH = pid_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [ERR_W-1:0] din,
    output logic [ERR_W-1:0] oldest,
    output logic             primed
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned SLOTS  = 2 ** PTR_W;

    localparam logic [PTR_W-1:0]  LAST = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    // Storage is rounded up to a power of two; slots past LAST are never addressed.
    logic [ERR_W-1:0]  hist_q [SLOTS];
    logic [PTR_W-1:0]  wp_q;
    logic [FILL_W-1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) hist_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < SLOTS; i++) hist_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
        end else if (push) begin
            hist_q[wp_q] <= din;
            wp_q         <= (wp_q == LAST) ? '0 : wp_q + 1'b1;
            if (fill_q != FULL) fill_q <= fill_q + 1'b1;
        end
    end

    assign oldest = hist_q[wp_q];
    assign primed = (fill_q == FULL);

endmodule

// File: rtl/d_term_pipe.sv
// Two-stage derivative term: saturated err - err[n-DEPTH], scaled by d_coeff.
module d_term_pipe import pid_pkg::*; #(
    parameter int unsigned ERR_W   = pid_pkg::ERR_W,
    parameter int unsigned DIFF_W  = pid_pkg::DIFF_W,
    parameter int unsigned COEFF_W = pid_pkg::COEFF_W,
    parameter int unsigned DEPTH   = pid_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ERR_W-1:0]          err_sat,
    input  logic                      err_vld,
    input  logic                      clr,
    input  logic [COEFF_W-1:0]        d_coeff,
    output logic [DIFF_W+COEFF_W-1:0] D_term,
    output logic                      D_vld,
    output logic                      primed
);

    localparam int unsigned PROD_W = DIFF_W + COEFF_W;

    logic [ERR_W-1:0]         oldest;
    logic signed [ERR_W:0]    diff;
    logic signed [DIFF_W-1:0] diff_sat;
    logic signed [DIFF_W-1:0] diff_q;
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic                     v1_q;
    logic [PROD_W-1:0]        d_term_q;
    logic                     d_vld_q;

    err_hist #(
        .ERR_W (ERR_W),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .push   (err_vld),
        .din    (err_sat),
        .oldest (oldest),
        .primed (primed)
    );

    // One extra bit keeps the subtraction exact; unprimed samples give no kick.
    always_comb begin
        diff     = $signed({err_sat[ERR_W-1], err_sat}) - $signed({oldest[ERR_W-1], oldest});
        diff_sat = primed ? DIFF_W'(sat_signed(32'(diff), ERR_W + 1, DIFF_W)) : '0;
        mul_a    = PROD_W'(diff_q);
        mul_b    = PROD_W'({1'b0, d_coeff});
        prod     = mul_a * mul_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            diff_q   <= '0;
            d_vld_q  <= 1'b0;
            d_term_q <= '0;
        end else if (clr) begin
            v1_q     <= 1'b0;
            diff_q   <= '0;
            d_vld_q  <= 1'b0;
            d_term_q <= '0;
        end else begin
            v1_q    <= err_vld;
            if (err_vld) diff_q <= diff_sat;
            d_vld_q <= v1_q;
            if (v1_q) d_term_q <= prod;
        end
    end

    assign D_term = d_term_q;
    assign D_vld  = d_vld_q;

endmodule
